// File: rtl/gpu_hub75_if.sv
// Paint-side write port of gpu_hub75.
//   write           write strobe from the paint logic
//   px_data         pixel index (planes) or {entry, colour} (palette)
//   column, row     pixel coordinate, 0..63 each
//   image_palette   1 = palette write
//   image_overlay   0 = image plane, 1 = overlay plane
//   write_available high when a write is accepted this cycle
interface gpu_hub75_if;
    logic       write;
    logic [7:0] px_data;
    logic [5:0] column;
    logic [5:0] row;
    logic       image_palette;
    logic       image_overlay;
    logic       write_available;

    modport master (
        output write, px_data, column, row, image_palette, image_overlay,
        input  write_available
    );

    modport slave (
        input  write, px_data, column, row, image_palette, image_overlay,
        output write_available
    );
endinterface

// File: rtl/gpu_hub75.sv
// Frame-buffer driver for a 64x64 HUB75 panel (1/32 scan).
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   bus (slave)        single-pixel / palette write port
//   to_screen_RGB0/1   {R,G,B} for the upper / lower half-panel
//   to_screen_CLK      panel shift clock
//   to_screen_ABCDE    row-pair address
//   to_screen_LATCH    row latch, active high
//   to_screen_nOE      output enable, active low
module gpu_hub75 (
    input  logic        clk,
    input  logic        rstn,
    gpu_hub75_if.slave  bus,
    output logic [2:0]  to_screen_RGB0,
    output logic [2:0]  to_screen_RGB1,
    output logic        to_screen_CLK,
    output logic [4:0]  to_screen_ABCDE,
    output logic        to_screen_LATCH,
    output logic        to_screen_nOE
);
    localparam int unsigned CNT_W      = 12;
    localparam int unsigned BANK_AW    = 11;
    localparam int unsigned BANK_DEPTH = 2048;
    localparam int unsigned CLEAR_LAST = 4095;
    localparam int unsigned SHIFT_LAST = 127;

    typedef enum logic [1:0] {S_CLEAR, S_SHIFT, S_BLANK, S_LATCH} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [4:0]         scan_row, scan_row_n;
    logic               lit, lit_n;
    logic [2:0]         rgb0_n, rgb1_n;
    logic               sclk_n, latch_n, noe_n, wa_n;
    logic [4:0]         abcde_n;

    // Each plane is split into an upper and lower half bank so both halves
    // of the panel are read in the same cycle. Index = {overlay, lower_half}.
    logic [3:0]         mem [4][BANK_DEPTH];
    logic [3:0]         rq  [4];
    logic [3:0]         we;
    logic [BANK_AW-1:0] waddr, raddr;
    logic [3:0]         wdata;
    logic [2:0]         pal [16];
    logic               accept;
    logic [5:0]         scan_col;
    logic [4:0]         rd_row;
    logic [2:0]         colour0, colour1;

    assign accept = bus.write & bus.write_available;

    // Write port: CLEAR sweep has priority, user writes only when available.
    always_comb begin
        we    = 4'b0000;
        waddr = {bus.row[4:0], bus.column};
        wdata = bus.px_data[3:0];
        if (state == S_CLEAR) begin
            waddr = cnt[BANK_AW-1:0];
            wdata = 4'h0;
            we[{1'b0, cnt[11]}] = 1'b1;
            we[{1'b1, cnt[11]}] = 1'b1;
        end else if (accept && !bus.image_palette) begin
            we[{bus.image_overlay, bus.row[5]}] = 1'b1;
        end
    end

    // Scan read runs two cycles ahead of the RGB register; around the latch
    // the prefetch already targets the next row.
    always_comb begin
        scan_col = 6'd0;
        rd_row   = scan_row;
        if (state == S_SHIFT)
            scan_col = 6'((8'(cnt[6:0]) + 8'd2) >> 1);
        if (state == S_BLANK || state == S_LATCH)
            rd_row = scan_row + 5'd1;
        raddr = {rd_row, scan_col};
    end

    // Scan RAMs: read-before-write, so a same-cycle write shows next frame.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b])
                mem[b][waddr] <= wdata;
            rq[b] <= mem[b][raddr];
        end
    end

    // Palette, identity after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++)
                pal[i] <= 3'(i);
        end else if (accept && bus.image_palette) begin
            pal[bus.px_data[7:4]] <= bus.px_data[2:0];
        end
    end

    // Overlay index 0 is transparent.
    assign colour0 = (rq[2] != 4'h0) ? pal[rq[2]] : pal[rq[0]];
    assign colour1 = (rq[3] != 4'h0) ? pal[rq[3]] : pal[rq[1]];

    // State and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state               <= S_CLEAR;
            cnt                 <= '0;
            scan_row            <= '0;
            lit                 <= 1'b0;
            to_screen_RGB0      <= 3'd0;
            to_screen_RGB1      <= 3'd0;
            to_screen_CLK       <= 1'b0;
            to_screen_ABCDE     <= 5'd0;
            to_screen_LATCH     <= 1'b0;
            to_screen_nOE       <= 1'b1;
            bus.write_available <= 1'b0;
        end else begin
            state               <= state_n;
            cnt                 <= cnt_n;
            scan_row            <= scan_row_n;
            lit                 <= lit_n;
            to_screen_RGB0      <= rgb0_n;
            to_screen_RGB1      <= rgb1_n;
            to_screen_CLK       <= sclk_n;
            to_screen_ABCDE     <= abcde_n;
            to_screen_LATCH     <= latch_n;
            to_screen_nOE       <= noe_n;
            bus.write_available <= wa_n;
        end
    end

    // Next state and next output values (describe the following cycle).
    always_comb begin
        state_n    = state;
        cnt_n      = cnt + CNT_W'(1);
        scan_row_n = scan_row;
        lit_n      = lit;
        rgb0_n     = to_screen_RGB0;
        rgb1_n     = to_screen_RGB1;
        sclk_n     = 1'b0;
        latch_n    = 1'b0;
        noe_n      = to_screen_nOE;
        abcde_n    = to_screen_ABCDE;
        wa_n       = bus.write_available;
        case (state)
            S_CLEAR: begin
                noe_n = 1'b1;
                if (cnt == CNT_W'(CLEAR_LAST)) begin
                    state_n = S_SHIFT;
                    cnt_n   = '0;
                    wa_n    = 1'b1;
                    rgb0_n  = colour0;
                    rgb1_n  = colour1;
                end
            end
            S_SHIFT: begin
                noe_n = ~lit;
                if (cnt == CNT_W'(SHIFT_LAST)) begin
                    state_n = S_BLANK;
                    cnt_n   = '0;
                    noe_n   = 1'b1;
                end else begin
                    // Odd cycle ends with CLK high; next column goes out as CLK falls.
                    sclk_n = ~cnt[0];
                    if (cnt[0]) begin
                        rgb0_n = colour0;
                        rgb1_n = colour1;
                    end
                end
            end
            S_BLANK: begin
                state_n = S_LATCH;
                latch_n = 1'b1;
                noe_n   = 1'b1;
                abcde_n = scan_row;
            end
            S_LATCH: begin
                state_n    = S_SHIFT;
                cnt_n      = '0;
                noe_n      = 1'b0;
                lit_n      = 1'b1;
                scan_row_n = scan_row + 5'd1;
                rgb0_n     = colour0;
                rgb1_n     = colour1;
            end
            default: state_n = S_CLEAR;
        endcase
    end
endmodule

// File: tb/tb_gpu_hub75.sv
module tb_gpu_hub75;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    gpu_hub75_if bus ();
    logic [2:0] rgb0, rgb1;
    logic       sclk, latch, noe;
    logic [4:0] abcde;

    gpu_hub75 dut (
        .clk             (clk),
        .rstn            (rstn),
        .bus             (bus),
        .to_screen_RGB0  (rgb0),
        .to_screen_RGB1  (rgb1),
        .to_screen_CLK   (sclk),
        .to_screen_ABCDE (abcde),
        .to_screen_LATCH (latch),
        .to_screen_nOE   (noe)
    );

    typedef struct {
        bit         pal;
        bit         ov;
        logic [7:0] data;
        logic [5:0] col;
        logic [5:0] row;
        int         pr;
        int         pc;
        logic [2:0] exp_rgb;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] m_img [64][64];
    logic [3:0] m_ov  [64][64];
    logic [2:0] m_pal [16];
    bit clk_prev, clk_now;
    vec_t tbl [10];

    function automatic logic [2:0] colour(int r, int c);
        if (m_ov[r][c] != 4'h0) return m_pal[m_ov[r][c]];
        return m_pal[m_img[r][c]];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) begin
                m_img[r][c] = 4'h0;
                m_ov[r][c]  = 4'h0;
            end
        for (int i = 0; i < 16; i++) m_pal[i] = 3'(i);
    endtask

    task automatic model_write(bit pal, bit ov, logic [7:0] d, int col, int row);
        if (pal)     m_pal[d[7:4]] = d[2:0];
        else if (ov) m_ov[row][col] = d[3:0];
        else         m_img[row][col] = d[3:0];
    endtask

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic summary_and_finish();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    task automatic timeout(string what);
        vectors++;
        miscompares++;
        $display("FAIL timeout %s: got no event expected one at %0t", what, $time);
        summary_and_finish();
    endtask

    task automatic step();
        @(negedge clk);
        clk_prev = clk_now;
        clk_now  = sclk;
    endtask

    task automatic wait_rise();
        int n = 0;
        forever begin
            step();
            if (!clk_prev && clk_now) return;
            n++;
            if (n > 300) begin timeout("panel_clk_rise"); return; end
        end
    endtask

    task automatic wait_latch(int row, int budget);
        int n = 0;
        forever begin
            step();
            if (latch && (row < 0 || int'(abcde) == row)) return;
            n++;
            if (n > budget) begin timeout("latch"); return; end
        end
    endtask

    task automatic drive_write(bit pal, bit ov, logic [7:0] d, int col, int row);
        bus.image_palette = pal;
        bus.image_overlay = ov;
        bus.px_data       = d;
        bus.column        = 6'(col);
        bus.row           = 6'(row);
        bus.write         = 1'b1;
        step();
        bus.write         = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_rgb0"},  int'(rgb0), 0);
        chk({tag, "_rgb1"},  int'(rgb1), 0);
        chk({tag, "_clk"},   int'(sclk), 0);
        chk({tag, "_abcde"}, int'(abcde), 0);
        chk({tag, "_latch"}, int'(latch), 0);
        chk({tag, "_noe"},   int'(noe), 1);
        chk({tag, "_wa"},    int'(bus.write_available), 0);
    endtask

    // CLEAR length, dark panel during CLEAR, writes during CLEAR ignored.
    task automatic clear_check(string tag);
        int first_wa = -1;
        bit noe_ok = 1'b1;
        bit rgb_ok = 1'b1;
        for (int i = 1; i <= 5000; i++) begin
            step();
            bus.write = 1'b0;
            if (noe !== 1'b1) noe_ok = 1'b0;
            if (rgb0 != 3'd0 || rgb1 != 3'd0) rgb_ok = 1'b0;
            if (bus.write_available) begin first_wa = i; break; end
            if (i == 100) begin
                bus.image_palette = 1'b1; bus.px_data = 8'h07; bus.write = 1'b1;
            end else if (i == 101) begin
                bus.image_palette = 1'b0; bus.image_overlay = 1'b0; bus.px_data = 8'h07;
                bus.column = 6'd7; bus.row = 6'd7; bus.write = 1'b1;
            end else if (i == 102) begin
                bus.image_palette = 1'b0; bus.image_overlay = 1'b1; bus.px_data = 8'h03;
                bus.column = 6'd40; bus.row = 6'd40; bus.write = 1'b1;
            end
        end
        bus.write = 1'b0;
        chk({tag, "_cycles"}, first_wa, 4096);
        chk({tag, "_noe_high"}, int'(noe_ok), 1);
        chk({tag, "_rgb_dark"}, int'(rgb_ok), 1);
    endtask

    // Whole-frame check; first = frame right after CLEAR (no preceding latch).
    task automatic check_frame(bit first);
        if (!first) wait_latch(31, 4400);
        for (int r = 0; r < 32; r++) begin
            for (int k = 0; k < 64; k++) begin
                wait_rise();
                chk($sformatf("pix_r%0d_c%0d_rgb0", r, k), int'(rgb0), int'(colour(r, k)));
                chk($sformatf("pix_r%0d_c%0d_rgb1", r + 32, k), int'(rgb1), int'(colour(r + 32, k)));
                if (k == 0)
                    chk($sformatf("noe_row%0d", r), int'(noe), (first && r == 0) ? 1 : 0);
            end
            wait_latch(-1, 8);
            chk($sformatf("abcde_row%0d", r), int'(abcde), r);
            chk($sformatf("latch_noe_row%0d", r), int'(noe), 1);
        end
    endtask

    task automatic probe(int r, int c, logic [2:0] exp_rgb, int idx);
        step();
        step();
        wait_latch((r % 32 + 31) % 32, 4400);
        repeat (c + 1) wait_rise();
        chk($sformatf("vec%0d_r%0d_c%0d", idx, r, c), int'((r >= 32) ? rgb1 : rgb0), int'(exp_rgb));
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 8'h12, 6'd31, 6'd31, 31, 31, 3'b010};
        tbl[1] = '{1'b0, 1'b0, 8'h05, 6'd5,  6'd40, 40, 5,  3'b101};
        tbl[2] = '{1'b0, 1'b0, 8'h02, 6'd10, 6'd3,  3,  10, 3'b010};
        tbl[3] = '{1'b0, 1'b1, 8'h07, 6'd10, 6'd3,  3,  10, 3'b111};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 6'd10, 6'd3,  3,  10, 3'b010};
        tbl[5] = '{1'b1, 1'b0, 8'h24, 6'd63, 6'd63, 31, 31, 3'b100};
        tbl[6] = '{1'b1, 1'b1, 8'h5B, 6'd0,  6'd0,  40, 5,  3'b011};
        tbl[7] = '{1'b0, 1'b0, 8'hF1, 6'd63, 6'd63, 63, 63, 3'b001};
        tbl[8] = '{1'b0, 1'b1, 8'h9F, 6'd0,  6'd0,  0,  0,  3'b111};
        tbl[9] = '{1'b1, 1'b0, 8'hF2, 6'd1,  6'd1,  0,  0,  3'b010};

        rstn = 1'b0;
        bus.write = 1'b0;
        bus.px_data = 8'h00;
        bus.column = 6'd0;
        bus.row = 6'd0;
        bus.image_palette = 1'b0;
        bus.image_overlay = 1'b0;
        clk_prev = 1'b0;
        clk_now = 1'b0;
        model_reset();
        repeat (3) step();
        check_reset_outputs("reset");

        rstn = 1'b1;
        clear_check("clear1");
        check_frame(1'b1);

        for (int i = 0; i < 10; i++) begin
            drive_write(tbl[i].pal, tbl[i].ov, tbl[i].data, int'(tbl[i].col), int'(tbl[i].row));
            model_write(tbl[i].pal, tbl[i].ov, tbl[i].data, int'(tbl[i].col), int'(tbl[i].row));
            probe(tbl[i].pr, tbl[i].pc, tbl[i].exp_rgb, i);
        end
        check_frame(1'b0);

        for (int round = 0; round < 2; round++) begin
            for (int n = 0; n < 30; n++) begin
                bit         p  = ($urandom_range(0, 3) == 0);
                bit         o  = 1'($urandom_range(0, 1));
                logic [7:0] d  = 8'($urandom);
                int         c  = int'($urandom_range(0, 63));
                int         r  = int'($urandom_range(0, 63));
                drive_write(p, o, d, c, r);
                model_write(p, o, d, c, r);
            end
            check_frame(1'b0);
        end

        // Reset pulse in the middle of a shift, with CLK high and the row lit.
        repeat (10) wait_rise();
        #1 rstn = 1'b0;
        #1 check_reset_outputs("async_rst");
        step();
        check_reset_outputs("rst_held");
        rstn = 1'b1;
        model_reset();
        clear_check("clear2");
        check_frame(1'b1);

        summary_and_finish();
    end
endmodule
